// File: rtl/move_recorder_pkg.sv
// Shared definitions for the move recorder: move encodings, state encodings and
// the default move-slot count.
package move_recorder_pkg;

  localparam int MAX_MOVES_DEF = 17;
  localparam int DEPTH_W_DEF   = 5;

  // Encoded so that the opposite of any move differs only in bit 0.
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    return dir ^ 2'b01;
  endfunction

endpackage

// File: rtl/move_recorder.sv
// Collects the search engine's moves into the packed ord word read by the
// 7-segment move display; blocks reversals and flags overflow/underflow.
module move_recorder
  import move_recorder_pkg::*;
#(
  parameter int MAX_MOVES = MAX_MOVES_DEF,
  parameter int DEPTH_W   = DEPTH_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   push_valid,
  input  logic [1:0]             push_dir,
  input  logic                   pop_valid,
  input  logic                   solved,
  output logic                   push_ack,
  output logic                   rev_rej,
  output logic [2*MAX_MOVES-1:0] ord,
  output logic [DEPTH_W-1:0]     depth,
  output logic                   comp,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic                   err
);

  localparam int ORD_W = 2 * MAX_MOVES;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_MOVES);

  state_e             state_q, state_d;
  logic [ORD_W-1:0]   ord_q, ord_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               push_ack_q, push_ack_d;
  logic               rev_rej_q, rev_rej_d;
  logic               comp_q, comp_d;
  logic               busy_q, busy_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               err_q, err_d;

  logic [DEPTH_W-1:0] depth_m1;
  logic [ORD_W-1:0]   top_word;
  logic [1:0]         top_dir;

  // Next-state logic: start dominates, then pop over push, then solved.
  always_comb begin
    state_d    = state_q;
    ord_d      = ord_q;
    depth_d    = depth_q;
    err_d      = err_q;
    comp_d     = comp_q;
    push_ack_d = 1'b0;
    rev_rej_d  = 1'b0;

    depth_m1 = depth_q - {{(DEPTH_W-1){1'b0}}, 1'b1};
    top_word = ord_q >> {depth_m1, 1'b0};
    top_dir  = top_word[1:0];

    if (start) begin
      state_d = ST_RECORD;
      ord_d   = {ORD_W{1'b0}};
      depth_d = {DEPTH_W{1'b0}};
      err_d   = 1'b0;
      comp_d  = 1'b0;
    end else if (state_q == ST_RECORD) begin
      if (pop_valid) begin
        if (depth_q != {DEPTH_W{1'b0}}) begin
          ord_d   = ord_q & ~(ORD_W'(2'b11) << {depth_m1, 1'b0});
          depth_d = depth_m1;
        end else begin
          err_d = 1'b1;
        end
      end else if (push_valid) begin
        if (depth_q == DEPTH_MAX) begin
          err_d = 1'b1;
        end else if ((depth_q != {DEPTH_W{1'b0}}) && (push_dir == opposite_dir(top_dir))) begin
          rev_rej_d = 1'b1;
        end else begin
          ord_d      = ord_q | (ORD_W'(push_dir) << {depth_q, 1'b0});
          depth_d    = depth_q + {{(DEPTH_W-1){1'b0}}, 1'b1};
          push_ack_d = 1'b1;
        end
      end else begin
        ord_d = ord_q;
      end

      if (solved) begin
        state_d = ST_DONE;
        comp_d  = 1'b1;
      end else begin
        state_d = ST_RECORD;
      end
    end else begin
      state_d = state_q;
    end

    busy_d  = (state_d == ST_RECORD);
    full_d  = (depth_d == DEPTH_MAX);
    empty_d = (depth_d == {DEPTH_W{1'b0}});
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ord_q      <= {ORD_W{1'b0}};
      depth_q    <= {DEPTH_W{1'b0}};
      push_ack_q <= 1'b0;
      rev_rej_q  <= 1'b0;
      comp_q     <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ord_q      <= ord_d;
      depth_q    <= depth_d;
      push_ack_q <= push_ack_d;
      rev_rej_q  <= rev_rej_d;
      comp_q     <= comp_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
    end
  end

  assign ord      = ord_q;
  assign depth    = depth_q;
  assign push_ack = push_ack_q;
  assign rev_rej  = rev_rej_q;
  assign comp     = comp_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign err      = err_q;

endmodule

// File: tb/tb_move_recorder.sv
// Directed, table-driven bench for move_recorder with hand-computed expectations.
module tb_move_recorder;

  localparam int MM = 17;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          push_valid = 1'b0;
  logic [1:0]    push_dir = 2'b00;
  logic          pop_valid = 1'b0;
  logic          solved = 1'b0;
  logic          push_ack, rev_rej, comp, busy, full, empty, err;
  logic [2*MM-1:0] ord;
  logic [DW-1:0] depth;

  int n_checks = 0;
  int n_fail   = 0;

  move_recorder dut (
    .clk(clk), .rst(rst), .start(start), .push_valid(push_valid),
    .push_dir(push_dir), .pop_valid(pop_valid), .solved(solved),
    .push_ack(push_ack), .rev_rej(rev_rej), .ord(ord), .depth(depth),
    .comp(comp), .busy(busy), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, start, push_valid;
    logic [1:0]    dir;
    logic          pop_valid, solved;
    logic          ack, rej;
    logic [33:0]   ord;
    logic [4:0]    depth;
    logic          comp, busy, err;
  } vec_t;

  localparam logic [1:0] U = 2'b00, D = 2'b01, R = 2'b10, L = 2'b11;

  function automatic vec_t mk(input logic r, input logic s, input logic pv, input logic [1:0] d,
                              input logic pp, input logic sv, input logic a, input logic rj,
                              input logic [33:0] o, input logic [4:0] dp, input logic c,
                              input logic b, input logic e);
    vec_t v;
    v.rst = r; v.start = s; v.push_valid = pv; v.dir = d; v.pop_valid = pp; v.solved = sv;
    v.ack = a; v.rej = rj; v.ord = o; v.depth = dp; v.comp = c; v.busy = b; v.err = e;
    return v;
  endfunction

  task automatic run(input vec_t v, input string name);
    logic exp_full, exp_empty;
    rst = v.rst; start = v.start; push_valid = v.push_valid; push_dir = v.dir;
    pop_valid = v.pop_valid; solved = v.solved;
    @(posedge clk);
    #1;
    exp_full  = (v.depth == 5'd17);
    exp_empty = (v.depth == 5'd0);
    n_checks++;
    if (push_ack !== v.ack || rev_rej !== v.rej || ord !== v.ord || depth !== v.depth ||
        comp !== v.comp || busy !== v.busy || err !== v.err || full !== exp_full ||
        empty !== exp_empty) begin
      n_fail++;
      $display("FAIL %s: got ack=%b rej=%b ord=%h depth=%0d comp=%b busy=%b full=%b empty=%b err=%b; want ack=%b rej=%b ord=%h depth=%0d comp=%b busy=%b full=%b empty=%b err=%b",
               name, push_ack, rev_rej, ord, depth, comp, busy, full, empty, err,
               v.ack, v.rej, v.ord, v.depth, v.comp, v.busy, exp_full, exp_empty, v.err);
    end
  endtask

  vec_t tbl[27];

  initial begin
    //              rst   start pv    dir pop   slv   ack   rej   ord         dp     comp  busy  err
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, R, 1'b0, 1'b0, 1'b1, 1'b0, 34'h2,      5'd1, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b1, 1'b0, 34'h2,      5'd2, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, L, 1'b0, 1'b0, 1'b1, 1'b0, 34'h32,     5'd3, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, U, 1'b0, 1'b1, 1'b0, 1'b0, 34'h32,     5'd3, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h32,     5'd3, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, U, 1'b1, 1'b0, 1'b0, 1'b0, 34'h32,     5'd3, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, U, 1'b0, 1'b1, 1'b0, 1'b0, 34'h32,     5'd3, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, L, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0,      5'd1, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, D, 1'b0, 1'b0, 1'b0, 1'b1, 34'h0,      5'd1, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, L, 1'b0, 1'b0, 1'b1, 1'b0, 34'hC,      5'd2, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, U, 1'b1, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b1, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, R, 1'b0, 1'b0, 1'b1, 1'b0, 34'h2,      5'd1, 1'b0, 1'b1, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b1, 1'b0, 34'h2,      5'd2, 1'b0, 1'b1, 1'b1);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, L, 1'b1, 1'b0, 1'b0, 1'b0, 34'h2,      5'd1, 1'b0, 1'b1, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, D, 1'b0, 1'b1, 1'b1, 1'b0, 34'h6,      5'd2, 1'b1, 1'b0, 1'b1);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b1, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 1'b1, R, 1'b0, 1'b0, 1'b1, 1'b0, 34'h2,      5'd1, 1'b0, 1'b1, 1'b0);
    tbl[21] = mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b1, 1'b0, 34'h2,      5'd2, 1'b0, 1'b1, 1'b0);
    tbl[22] = mk(1'b0, 1'b0, 1'b1, R, 1'b0, 1'b0, 1'b1, 1'b0, 34'h22,     5'd3, 1'b0, 1'b1, 1'b0);
    tbl[23] = mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b1, 1'b0, 34'h22,     5'd4, 1'b0, 1'b1, 1'b0);
    tbl[24] = mk(1'b0, 1'b0, 1'b1, R, 1'b0, 1'b0, 1'b1, 1'b0, 34'h222,    5'd5, 1'b0, 1'b1, 1'b0);
    tbl[25] = mk(1'b1, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b0, 1'b0);
    tbl[26] = mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,      5'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 27; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
    end

    // Fill to capacity with alternating RIGHT/UP, then overflow and pop back.
    begin
      logic [33:0] exp_ord;
      logic [1:0]  d;
      exp_ord = 34'h0;
      run(mk(1'b0, 1'b1, 1'b0, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0, 5'd0, 1'b0, 1'b1, 1'b0), "fill_start");
      for (int k = 0; k < 17; k++) begin
        d = (k % 2 == 0) ? R : U;
        exp_ord = exp_ord | (34'(d) << (2 * k));
        run(mk(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0, exp_ord, 5'(k + 1), 1'b0, 1'b1, 1'b0),
            $sformatf("fill_push%0d", k));
      end
      run(mk(1'b0, 1'b0, 1'b1, U, 1'b0, 1'b0, 1'b0, 1'b0, 34'h2_2222_2222, 5'd17, 1'b0, 1'b1, 1'b1),
          "overflow_push");
      run(mk(1'b0, 1'b0, 1'b0, U, 1'b1, 1'b0, 1'b0, 1'b0, 34'h0_2222_2222, 5'd16, 1'b0, 1'b1, 1'b1),
          "pop_after_full");
      run(mk(1'b0, 1'b0, 1'b1, L, 1'b0, 1'b0, 1'b1, 1'b0, 34'h3_2222_2222, 5'd17, 1'b0, 1'b1, 1'b1),
          "refill_last_slot");
      run(mk(1'b0, 1'b0, 1'b0, U, 1'b0, 1'b1, 1'b0, 1'b0, 34'h3_2222_2222, 5'd17, 1'b1, 1'b0, 1'b1),
          "solve_full");
    end

    rst = 1'b0; start = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; solved = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
